// File: rtl/rtx_pixel_dispatcher.sv
// rtx_pixel_dispatcher
//   Hands out pixel jobs in raster order to NUM_CORES rtx cores, merges the
//   finished pixels onto the single frame-buffer write port and sequences
//   frames (drain before next frame, frame counter, overwrite latch).
//
// Ports
//   clk, rst                     clock, async active-high reset
//   start_en                     dispatch enable; low stalls new jobs
//   scene_dirty, force_overwrite scene-change event / force overwrite
//   job_req/job_grant/job_h/v    job handshake (one-hot grant, raster coords)
//   res_valid/res_ready/res_*    result handshake (packed per core)
//   out_valid/out_pixel/out_h/v  registered frame-buffer write
//   out_overwrite                overwrite flag for the current frame
//   frame_count, frame_done      completed frames, end-of-frame pulse
//   busy                         dispatcher not idle
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start_en
// DISPATCH  | granting jobs in raster order
// DRAIN     | all jobs issued, waiting for outstanding results
// FRAME_END | one cycle: count frame, latch overwrite, pulse frame_done
module rtx_pixel_dispatcher #(
   parameter int NUM_CORES = 4,
   parameter int H_RES     = 1280,
   parameter int V_RES     = 720,
   parameter int PIX_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_en,
   input  logic                     scene_dirty,
   input  logic                     force_overwrite,
   input  logic [NUM_CORES-1:0]     job_req,
   output logic [NUM_CORES-1:0]     job_grant,
   output logic [10:0]              job_h,
   output logic [9:0]               job_v,
   input  logic [NUM_CORES-1:0]     res_valid,
   input  logic [NUM_CORES*PIX_W-1:0] res_pixel,
   input  logic [NUM_CORES*11-1:0]  res_h,
   input  logic [NUM_CORES*10-1:0]  res_v,
   output logic [NUM_CORES-1:0]     res_ready,
   output logic                     out_valid,
   output logic [PIX_W-1:0]         out_pixel,
   output logic [10:0]              out_h,
   output logic [9:0]               out_v,
   output logic                     out_overwrite,
   output logic [7:0]               frame_count,
   output logic                     frame_done,
   output logic                     busy
);

   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int OW = $clog2(NUM_CORES) + 2;

   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_FRAME_END} state_t;

   state_t           state_q, state_d;
   logic [10:0]      job_h_q, job_h_d;
   logic [9:0]       job_v_q, job_v_d;
   logic [PW-1:0]    job_ptr_q, job_ptr_d;
   logic [PW-1:0]    res_ptr_q, res_ptr_d;
   logic [OW-1:0]    outstanding_q, outstanding_d;
   logic             dirty_sticky_q, dirty_sticky_d;
   logic             out_valid_q, out_valid_d;
   logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
   logic [10:0]      out_h_q, out_h_d;
   logic [9:0]       out_v_q, out_v_d;
   logic             out_overwrite_q, out_overwrite_d;
   logic [7:0]       frame_count_q, frame_count_d;
   logic             frame_done_q, frame_done_d;
   logic             busy_q, busy_d;

   logic [NUM_CORES-1:0] job_grant_c, res_ready_c;
   logic                 job_xfer, res_acc, last_pix;
   int                   res_idx;

   // Round-robin pick: first set request at or above ptr, wrapping.
   // Iterating downward lets the lowest offset overwrite the choice.
   function automatic logic [NUM_CORES-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                                    input logic [PW-1:0] ptr);
      logic [NUM_CORES-1:0] g;
      int idx;
      g = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_CORES;
         if (req[idx]) begin
            g      = '0;
            g[idx] = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic int onehot_idx(input logic [NUM_CORES-1:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < NUM_CORES; i++)
         if (oh[i]) r = i;
      return r;
   endfunction

   always_comb begin
      job_grant_c = '0;
      res_ready_c = '0;
      if (state_q == S_DISPATCH && start_en)
         job_grant_c = rr_pick(job_req, job_ptr_q);
      // Accepting with nothing outstanding would underflow the counter.
      if (state_q != S_IDLE && outstanding_q != '0)
         res_ready_c = rr_pick(res_valid, res_ptr_q);
   end

   assign job_xfer = |job_grant_c;
   assign res_acc  = |res_ready_c;
   assign last_pix = (job_h_q == 11'(H_RES - 1)) && (job_v_q == 10'(V_RES - 1));
   assign res_idx  = onehot_idx(res_ready_c);

   always_comb begin
      state_d         = state_q;
      job_h_d         = job_h_q;
      job_v_d         = job_v_q;
      job_ptr_d       = job_ptr_q;
      res_ptr_d       = res_ptr_q;
      outstanding_d   = outstanding_q;
      dirty_sticky_d  = dirty_sticky_q | scene_dirty;
      out_valid_d     = res_acc;
      out_pixel_d     = out_pixel_q;
      out_h_d         = out_h_q;
      out_v_d         = out_v_q;
      out_overwrite_d = out_overwrite_q;
      frame_count_d   = frame_count_q;

      if (job_xfer) begin
         job_ptr_d = PW'((onehot_idx(job_grant_c) + 1) % NUM_CORES);
         if (job_h_q == 11'(H_RES - 1)) begin
            job_h_d = '0;
            job_v_d = (job_v_q == 10'(V_RES - 1)) ? '0 : job_v_q + 10'd1;
         end else begin
            job_h_d = job_h_q + 11'd1;
         end
      end

      if (res_acc) begin
         res_ptr_d   = PW'((res_idx + 1) % NUM_CORES);
         out_pixel_d = res_pixel[res_idx*PIX_W +: PIX_W];
         out_h_d     = res_h[res_idx*11 +: 11];
         out_v_d     = res_v[res_idx*10 +: 10];
      end

      case ({job_xfer, res_acc})
         2'b10:   outstanding_d = outstanding_q + OW'(1);
         2'b01:   outstanding_d = outstanding_q - OW'(1);
         default: outstanding_d = outstanding_q;
      endcase

      case (state_q)
         S_IDLE:     if (start_en) state_d = S_DISPATCH;
         S_DISPATCH: if (job_xfer && last_pix) state_d = S_DRAIN;
         S_DRAIN:    if (outstanding_q == '0) state_d = S_FRAME_END;
         S_FRAME_END: begin
            state_d         = start_en ? S_DISPATCH : S_IDLE;
            // A scene_dirty arriving now is folded into this latch only.
            out_overwrite_d = force_overwrite | dirty_sticky_q | scene_dirty;
            dirty_sticky_d  = 1'b0;
            frame_count_d   = frame_count_q + 8'd1;
         end
         default:    state_d = S_IDLE;
      endcase

      frame_done_d = (state_d == S_FRAME_END);
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         job_h_q         <= '0;
         job_v_q         <= '0;
         job_ptr_q       <= '0;
         res_ptr_q       <= '0;
         outstanding_q   <= '0;
         dirty_sticky_q  <= 1'b0;
         out_valid_q     <= 1'b0;
         out_pixel_q     <= '0;
         out_h_q         <= '0;
         out_v_q         <= '0;
         out_overwrite_q <= 1'b1;
         frame_count_q   <= '0;
         frame_done_q    <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         job_h_q         <= job_h_d;
         job_v_q         <= job_v_d;
         job_ptr_q       <= job_ptr_d;
         res_ptr_q       <= res_ptr_d;
         outstanding_q   <= outstanding_d;
         dirty_sticky_q  <= dirty_sticky_d;
         out_valid_q     <= out_valid_d;
         out_pixel_q     <= out_pixel_d;
         out_h_q         <= out_h_d;
         out_v_q         <= out_v_d;
         out_overwrite_q <= out_overwrite_d;
         frame_count_q   <= frame_count_d;
         frame_done_q    <= frame_done_d;
         busy_q          <= busy_d;
      end
   end

   assign job_grant     = job_grant_c;
   assign res_ready     = res_ready_c;
   assign job_h         = job_h_q;
   assign job_v         = job_v_q;
   assign out_valid     = out_valid_q;
   assign out_pixel     = out_pixel_q;
   assign out_h         = out_h_q;
   assign out_v         = out_v_q;
   assign out_overwrite = out_overwrite_q;
   assign frame_count   = frame_count_q;
   assign frame_done    = frame_done_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_rtx_pixel_dispatcher.sv
// Bench for rtx_pixel_dispatcher: 2 cores, 4x2 frame, cores modelled as
// per-core result FIFOs returning each pixel 3 cycles after its grant.
module tb_rtx_pixel_dispatcher;

   localparam int NC = 2;
   localparam int HR = 4;
   localparam int VR = 2;
   localparam int PXW = 16;
   localparam int NPIX = HR * VR;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_en = 1'b0;
   logic              scene_dirty = 1'b0;
   logic              force_overwrite = 1'b0;
   logic [NC-1:0]     job_req = '0;
   logic [NC-1:0]     job_grant;
   logic [10:0]       job_h;
   logic [9:0]        job_v;
   logic [NC-1:0]     res_valid = '0;
   logic [NC*PXW-1:0] res_pixel = '0;
   logic [NC*11-1:0]  res_h = '0;
   logic [NC*10-1:0]  res_v = '0;
   logic [NC-1:0]     res_ready;
   logic              out_valid;
   logic [PXW-1:0]    out_pixel;
   logic [10:0]       out_h;
   logic [9:0]        out_v;
   logic              out_overwrite;
   logic [7:0]        frame_count;
   logic              frame_done;
   logic              busy;

   rtx_pixel_dispatcher #(.NUM_CORES(NC), .H_RES(HR), .V_RES(VR), .PIX_W(PXW)) dut (
      .clk(clk), .rst(rst), .start_en(start_en), .scene_dirty(scene_dirty),
      .force_overwrite(force_overwrite), .job_req(job_req), .job_grant(job_grant),
      .job_h(job_h), .job_v(job_v), .res_valid(res_valid), .res_pixel(res_pixel),
      .res_h(res_h), .res_v(res_v), .res_ready(res_ready), .out_valid(out_valid),
      .out_pixel(out_pixel), .out_h(out_h), .out_v(out_v), .out_overwrite(out_overwrite),
      .frame_count(frame_count), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // core model
   logic [10:0] q_h[NC][8];
   logic [9:0]  q_v[NC][8];
   int          q_rdy[NC][8];
   int          q_wr[NC];
   int          q_rd[NC];
   logic        hold = 1'b0;
   logic [NC-1:0] spur = '0;
   logic        dirty_at_fe = 1'b0;

   // scoreboard
   int          cyc = 0;
   int          outst = 0;
   int          frames = 0;
   int          frame_grants = 0;
   int          n_out = 0;
   logic [NPIX-1:0] seen = '0;
   logic [10:0] exp_h = '0;
   logic [9:0]  exp_v = '0;
   logic        exp_ow[8];
   logic [NC-1:0] s_grant, s_ready;
   logic [10:0] s_h;
   logic [9:0]  s_v;
   logic        s_out_valid;

   typedef struct {
      logic        en;
      logic        sd;
      logic [1:0]  g;
      logic [10:0] h;
      logic [9:0]  v;
   } vec_t;
   vec_t tbl[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] pix_of(input logic [10:0] h, input logic [9:0] v);
      return 16'hA5C3 ^ {v[4:0], h};
   endfunction

   task automatic drive_res();
      for (int i = 0; i < NC; i++) begin
         logic nonempty;
         int   slot;
         slot = q_rd[i] % 8;
         nonempty = (q_wr[i] != q_rd[i]) && (q_rdy[i][slot] <= cyc) && !hold;
         res_valid[i] = nonempty | spur[i];
         res_h[i*11 +: 11]     = nonempty ? q_h[i][slot] : 11'd0;
         res_v[i*10 +: 10]     = nonempty ? q_v[i][slot] : 10'd0;
         res_pixel[i*PXW +: PXW] = nonempty ? pix_of(q_h[i][slot], q_v[i][slot]) : 16'd0;
      end
   endtask

   // One cycle: called just after a negedge with inputs already driven.
   task automatic step();
      int gcyc;
      int idx;
      #1;
      s_grant = job_grant;
      s_ready = res_ready;
      s_h = job_h;
      s_v = job_v;
      s_out_valid = out_valid;
      if (s_grant != '0) begin
         chk("grant_onehot", $countones(s_grant), 1);
         chk("grant_without_req", s_grant & ~job_req, 0);
         chk("job_h_raster", s_h, exp_h);
         chk("job_v_raster", s_v, exp_v);
      end
      if (s_ready != '0) begin
         chk("ready_onehot", $countones(s_ready), 1);
         chk("ready_without_valid", s_ready & ~res_valid, 0);
      end
      if (out_valid) begin
         chk("out_pixel", out_pixel, pix_of(out_h, out_v));
         chk("out_overwrite", out_overwrite, exp_ow[frames]);
         idx = int'(out_v) * HR + int'(out_h);
         if (idx < NPIX) begin
            chk("pixel_duplicate", seen[idx], 0);
            seen[idx] = 1'b1;
         end else begin
            chk("pixel_range", idx, 0);
         end
         n_out++;
      end
      if (frame_done) begin
         chk("frame_pixels", n_out, NPIX);
         chk("frame_all_seen", seen, {NPIX{1'b1}});
         chk("frame_outstanding", outst, 0);
         chk("frame_count_at_done", frame_count, frames);
         chk("overwrite_at_done", out_overwrite, exp_ow[frames]);
         frames++;
         n_out = 0;
         seen = '0;
         frame_grants = 0;
         if (dirty_at_fe) scene_dirty = 1'b1;
      end
      gcyc = cyc;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NC; i++) begin
         if (s_grant[i]) begin
            q_h[i][q_wr[i] % 8] = s_h;
            q_v[i][q_wr[i] % 8] = s_v;
            q_rdy[i][q_wr[i] % 8] = gcyc + 3;
            q_wr[i]++;
            outst++;
            frame_grants++;
            if (exp_h == 11'(HR - 1)) begin
               exp_h = '0;
               exp_v = (exp_v == 10'(VR - 1)) ? 10'd0 : exp_v + 10'd1;
            end else begin
               exp_h = exp_h + 11'd1;
            end
         end
         if (s_ready[i] && res_valid[i]) begin
            q_rd[i]++;
            outst--;
         end
      end
      scene_dirty = 1'b0;
      drive_res();
   endtask

   task automatic run_frame(input int max_cyc);
      int start;
      start = frames;
      for (int k = 0; k < max_cyc; k++) begin
         step();
         if (frames != start) break;
      end
      chk("frame_end_reached", frames, start + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_ow[0] = 1'b1; exp_ow[1] = 1'b1; exp_ow[2] = 1'b0; exp_ow[3] = 1'b1;
      for (int i = 4; i < 8; i++) exp_ow[i] = 1'b0;
      for (int i = 0; i < NC; i++) begin q_wr[i] = 0; q_rd[i] = 0; end

      // {en, scene_dirty, grant, job_h, job_v}; row 0 is the IDLE cycle
      tbl[0] = '{1'b1, 1'b0, 2'b00, 11'd0, 10'd0};
      tbl[1] = '{1'b1, 1'b0, 2'b01, 11'd0, 10'd0};
      tbl[2] = '{1'b1, 1'b0, 2'b10, 11'd1, 10'd0};
      tbl[3] = '{1'b1, 1'b0, 2'b01, 11'd2, 10'd0};
      for (int r = 4; r < 14; r++) tbl[r] = '{1'b0, (r == 6), 2'b00, 11'd3, 10'd0};
      tbl[14] = '{1'b1, 1'b0, 2'b10, 11'd3, 10'd0};
      tbl[15] = '{1'b1, 1'b0, 2'b01, 11'd0, 10'd1};
      tbl[16] = '{1'b1, 1'b0, 2'b10, 11'd1, 10'd1};
      tbl[17] = '{1'b1, 1'b0, 2'b01, 11'd2, 10'd1};
      tbl[18] = '{1'b1, 1'b0, 2'b10, 11'd3, 10'd1};
      tbl[19] = '{1'b1, 1'b0, 2'b00, 11'd0, 10'd0};

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_out_overwrite", out_overwrite, 1);
      chk("rst_job_hv", {job_h, job_v}, 0);
      chk("rst_out_hv_pixel", {out_h, out_v, out_pixel}, 0);
      @(negedge clk);
      rst = 1'b0;
      job_req = 2'b11;
      drive_res();

      // frame 1: raster order, start_en pause, scene_dirty mid-frame
      for (int r = 0; r < 20; r++) begin
         start_en = tbl[r].en;
         scene_dirty = tbl[r].sd;
         #1;
         chk($sformatf("tbl%0d_grant", r), job_grant, tbl[r].g);
         chk($sformatf("tbl%0d_job_h", r), job_h, tbl[r].h);
         chk($sformatf("tbl%0d_job_v", r), job_v, tbl[r].v);
         step();
      end
      chk("drain_busy", busy, 1);
      run_frame(40);
      chk("frame_count_1", frame_count, 1);

      // frame 2: hold results so both cores present at once
      hold = 1'b1;
      drive_res();
      repeat (5) step();
      hold = 1'b0;
      drive_res();
      #1;
      chk("collision_valid_both", res_valid, 2'b11);
      chk("collision_ready_onehot", $countones(res_ready), 1);
      run_frame(60);
      chk("frame_count_2", frame_count, 2);

      // frame 3: scene_dirty exactly in its FRAME_END cycle
      dirty_at_fe = 1'b1;
      run_frame(60);
      dirty_at_fe = 1'b0;
      chk("frame_count_3", frame_count, 3);
      chk("overwrite_from_fe_dirty", out_overwrite, 1);

      // frame 4: that event must not have carried into frame 5
      run_frame(60);
      job_req = 2'b00;
      chk("frame_count_4", frame_count, 4);
      chk("overwrite_not_sticky", out_overwrite, 0);

      // spurious results with nothing outstanding are ignored
      spur = 2'b11;
      drive_res();
      step();
      chk("spurious_ready_a", s_ready, 0);
      step();
      chk("spurious_ready_b", s_ready, 0);
      spur = 2'b00;
      drive_res();
      step();
      chk("spurious_no_out", s_out_valid, 0);

      // reset in DRAIN with two results outstanding
      job_req = 2'b11;
      for (int k = 0; k < 40; k++) begin
         step();
         if (frame_grants == NPIX && outst == 2) break;
      end
      chk("reach_drain_outst2", outst, 2);
      chk("reach_drain_grants", frame_grants, NPIX);
      chk("drain_busy_pre_rst", busy, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_busy", busy, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst2_busy", busy, 0);
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_frame_count", frame_count, 0);
      chk("rst2_out_overwrite", out_overwrite, 1);
      chk("rst2_job_h", job_h, 0);
      chk("rst2_job_v", job_v, 0);
      chk("rst2_res_ready", res_ready, 0);
      for (int i = 0; i < NC; i++) begin q_wr[i] = 0; q_rd[i] = 0; end
      outst = 0; frame_grants = 0; n_out = 0; seen = '0;
      exp_h = '0; exp_v = '0;
      drive_res();
      rst = 1'b0;
      step();
      #1;
      chk("post_rst_first_grant", job_grant, 2'b01);
      chk("post_rst_first_hv", {job_h, job_v}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
